// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe board definitions: move/direction codes, push-button
// indices and the direction-FSM state type used by the input encoder.
package ttt_pkg;

  localparam logic [2:0] DIR_IDLE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_RIGHT = 3'b011;
  localparam logic [2:0] DIR_LEFT  = 3'b100;

  localparam int KEY_CONFIRM = 0;
  localparam int KEY_RIGHT   = 1;
  localparam int KEY_LEFT    = 2;
  localparam int KEY_DOWN    = 3;
  localparam int KEY_UP      = 4;
  localparam int NUM_KEYS    = 5;

  typedef enum logic {D_IDLE, D_HELD} dir_state_t;

  // dirs is the debounced direction slice [KEY_UP:KEY_RIGHT]
  function automatic logic dirs_onehot(input logic [3:0] dirs);
    return (dirs != 4'd0) && ((dirs & (dirs - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [2:0] dir_code(input logic [3:0] dirs);
    logic [2:0] code;
    code = DIR_IDLE;
    case (dirs)
      4'b0001: code = DIR_RIGHT;
      4'b0010: code = DIR_LEFT;
      4'b0100: code = DIR_DOWN;
      4'b1000: code = DIR_UP;
      default: code = DIR_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: active-low input inverted, 2-FF synchronized, then
// debounced by requiring DEBOUNCE_CYCLES consecutive disagreeing samples.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic pressed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The count restarts whenever the synchronized level agrees with the
  // accepted level, so any bounce back discards the partial run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
      if (sync2 == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        pressed <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_move_encoder.sv
// Turns five bouncy active-low buttons into one-cycle move codes and confirm
// pulses. Optional auto-repeat of a held direction: define DIR_REPEAT_EN.
module key_move_encoder
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] key_n,
  output logic [2:0] dir,
  output logic       confirm
);

  // dir (non-zero) and confirm are single-cycle strobes with no ready:
  // the consumer samples them every cycle and cannot stall the encoder.

  logic [NUM_KEYS-1:0] lvl;
  logic                conf_d;
  logic                conf_rise;
  logic [3:0]          dirs;
  logic                one_dir;
  dir_state_t          state;
  dir_state_t          state_nxt;
  logic [2:0]          dir_nxt;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (clk),
      .resetn (resetn),
      .key_n  (key_n[k]),
      .pressed(lvl[k])
    );
  end

  assign conf_rise = lvl[KEY_CONFIRM] & ~conf_d;
  assign dirs      = lvl[KEY_UP:KEY_RIGHT];
  assign one_dir   = dirs_onehot(dirs);

`ifdef DIR_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_V  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] PERIOD_V = REP_W'(REPEAT_PERIOD);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_nxt;
  logic             rep_first;
  logic             rep_first_nxt;
  logic [3:0]       held_dirs;
  logic             rep_fire;

  // Count only while the same single direction stays held with no confirm
  // edge; anything else (including entering D_HELD) restarts the delay.
  always_comb begin
    rep_cnt_nxt   = '0;
    rep_first_nxt = 1'b0;
    rep_fire      = 1'b0;
    if (state == D_HELD && one_dir && dirs == held_dirs && !conf_rise) begin
      rep_first_nxt = rep_first;
      if (rep_cnt + 1'b1 == (rep_first ? PERIOD_V : DELAY_V)) begin
        rep_fire      = 1'b1;
        rep_first_nxt = 1'b1;
      end else begin
        rep_cnt_nxt = rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
      held_dirs <= '0;
    end else begin
      rep_cnt   <= rep_cnt_nxt;
      rep_first <= rep_first_nxt;
      held_dirs <= dirs;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    dir_nxt   = DIR_IDLE;
    case (state)
      D_IDLE: begin
        if (dirs != 4'd0) begin
          state_nxt = D_HELD;
          if (one_dir && !conf_rise) dir_nxt = dir_code(dirs);
        end
      end
      D_HELD: begin
        if (dirs == 4'd0) state_nxt = D_IDLE;
`ifdef DIR_REPEAT_EN
        if (rep_fire) dir_nxt = dir_code(dirs);
`endif
      end
      default: state_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= D_IDLE;
      conf_d  <= 1'b0;
      dir     <= DIR_IDLE;
      confirm <= 1'b0;
    end else begin
      state   <= state_nxt;
      conf_d  <= lvl[KEY_CONFIRM];
      dir     <= dir_nxt;
      confirm <= conf_rise;
    end
  end

endmodule

// File: tb/tb_key_move_encoder.sv
// Bench for key_move_encoder: randomized button stimulus, expected pulses from
// a behavioural model pushed to a queue, compared by an independent monitor.
module tb_key_move_encoder;

  localparam int DEB    = 4;
  localparam int DELAY  = 8;
  localparam int PERIOD = 4;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic [4:0] key_n  = 5'b11111;
  logic [2:0] dir;
  logic       confirm;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // {edge number, dir, confirm}
  logic [35:0] exp_q[$];

  // model state: raw history, accepted levels, disagreement run lengths
  logic [4:0] m_hist1, m_hist2, m_lvl;
  logic       m_conf_d;
  int         m_run[5];
  logic       m_idle;
  int         m_anchor;
  int         m_repeats;
  logic [3:0] m_held;

  key_move_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_PERIOD  (PERIOD)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (key_n),
    .dir    (dir),
    .confirm(confirm)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got dir=%0d confirm=%0d, expected dir=%0d confirm=%0d",
                  name, cyc, act[3:1], act[0], exp[3:1], exp[0]);
  endtask

  // ---------------- reference model ----------------
  // Direction key index 1..4 (right, left, down, up) to its move code.
  function automatic logic [2:0] code_of(input logic [3:0] d);
    logic [2:0] tbl [4];
    tbl[0] = 3'd3;  // right
    tbl[1] = 3'd4;  // left
    tbl[2] = 3'd2;  // down
    tbl[3] = 3'd1;  // up
    for (int i = 0; i < 4; i++) if (d[i]) return tbl[i];
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_hist1 = '0; m_hist2 = '0; m_lvl = '0; m_conf_d = 1'b0;
    for (int k = 0; k < 5; k++) m_run[k] = 0;
    m_idle = 1'b1; m_anchor = 0; m_repeats = 0; m_held = '0;
    exp_q.delete();
  endtask

  // Advance the model over the coming clock edge, given key_n as now driven.
  task automatic model_step();
    logic [4:0] r;
    logic       cr;
    logic [3:0] d;
    logic [2:0] code;
    int         e;
    r    = ~key_n;
    e    = cyc + 1;
    cr   = m_lvl[0] & ~m_conf_d;
    d    = m_lvl[4:1];
    code = 3'd0;
    if (m_idle) begin
      if (d != 4'd0) begin
        m_idle = 1'b0;
        if ($countones(d) == 1 && !cr) code = code_of(d);
        m_anchor = e; m_repeats = 0; m_held = d;
      end
    end else begin
`ifdef DIR_REPEAT_EN
      if ($countones(d) == 1 && d == m_held && !cr) begin
        if (e - m_anchor == ((m_repeats == 0) ? DELAY : PERIOD)) begin
          code = code_of(d); m_anchor = e; m_repeats++;
        end
      end else begin
        m_anchor = e; m_repeats = 0; m_held = d;
      end
`endif
      if (d == 4'd0) m_idle = 1'b1;
    end
    if (code != 3'd0 || cr) exp_q.push_back({e[31:0], code, cr});
    // A level is accepted once the synchronized input (two edges old) has
    // disagreed with it for DEB consecutive edges.
    m_conf_d = m_lvl[0];
    for (int k = 0; k < 5; k++) begin
      if (m_hist2[k] == m_lvl[k]) m_run[k] = 0;
      else if (m_run[k] + 1 == DEB) begin m_lvl[k] = m_hist2[k]; m_run[k] = 0; end
      else m_run[k]++;
    end
    m_hist2 = m_hist1;
    m_hist1 = r;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] kn);
    @(negedge clk);
    key_n = kn;
    if (resetn) model_step();
  endtask

  task automatic hold(input logic [4:0] kn, input int n);
    for (int i = 0; i < n; i++) drive(kn);
  endtask

  task automatic pulse_reset(input logic [4:0] kn, input int n);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    key_n  = kn;
    model_reset();
    #1;
    check("async_reset", {dir, confirm}, 4'b0000);
    repeat (n) @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] ecyc;
    logic [3:0]  exp;
    string       name;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (resetn) begin
        while (exp_q.size() > 0 && exp_q[0][35:4] < cyc) begin
          n_checks++;
          $display("FAIL missed_pulse: expected dir=%0d confirm=%0d at cycle %0d, got nothing by cycle %0d",
                   exp_q[0][3:1], exp_q[0][0], exp_q[0][35:4], cyc);
          void'(exp_q.pop_front());
        end
        exp  = 4'b0000;
        name = "idle_output";
        if (exp_q.size() > 0) begin
          ecyc = exp_q[0][35:4];
          if (ecyc == cyc) begin
            exp  = exp_q[0][3:0];
            name = "pulse";
            void'(exp_q.pop_front());
          end
        end
        check(name, {dir, confirm}, exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] kn;
    int         idx;
    model_reset();

    // reset with random buttons: outputs clear at once
    #1;
    resetn = 1'b0;
    key_n  = 5'($urandom());
    #1;
    check("reset_immediate", {dir, confirm}, 4'b0000);
    repeat (3) @(negedge clk);
    check("reset_hold", {dir, confirm}, 4'b0000);
    @(negedge clk);
    key_n  = 5'b11111;
    resetn = 1'b1;
    model_step();
    hold(5'b11111, 50);

    // each direction alone, random hold lengths
    hold(5'b01111, 20); hold(5'b11111, 12);
    hold(5'b10111, $urandom_range(10, 16)); hold(5'b11111, 12);
    hold(5'b11101, $urandom_range(10, 16)); hold(5'b11111, 12);
    hold(5'b11011, $urandom_range(10, 16)); hold(5'b11111, 12);

    // bouncing down key, then settled low
    for (int i = 0; i < 6; i++) begin hold(5'b10111, 2); hold(5'b11111, 2); end
    hold(5'b10111, 15); hold(5'b11111, 12);

    // up+right chord is discarded, then left alone is accepted
    hold(5'b01101, 15); hold(5'b11111, 12);
    hold(5'b11011, 15); hold(5'b11111, 12);

    // confirm and down together: confirm wins; later confirm alone
    hold(5'b10110, 15); hold(5'b11111, 12);
    hold(5'b11110, 12); hold(5'b11111, 12);

    // reset in the middle of a right hold, key still held afterwards
    hold(5'b11101, 5);
    pulse_reset(5'b11101, 2);
    hold(5'b11101, 20); hold(5'b11111, 12);

    // long right hold (auto-repeat when enabled)
    hold(5'b11101, 30); hold(5'b11111, 12);

    // randomized button activity with a reset in the middle
    kn = 5'b11111;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 4);
        kn[idx] = ~kn[idx];
      end
      drive(kn);
      if (i == 200) pulse_reset(kn, $urandom_range(0, 3));
    end
    hold(5'b11111, 30);

    while (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL leftover_pulse: expected dir=%0d confirm=%0d at cycle %0d, never seen",
               exp_q[0][3:1], exp_q[0][0], exp_q[0][35:4]);
      void'(exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_move_encoder.md
Name: key_move_encoder

Overview:
- Input-conditioning stage directly upstream of the cursor-movement and game-control logic.
- Converts the raw, bouncy, active-low board push-buttons into clean single-cycle move commands.
- Outputs: a 3-bit direction code (Idle/Up/Down/Right/Left) and a one-cycle confirm pulse, in the exact format the cursor and control FSM consume.
- Each physical press yields exactly one command.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat (used only with DIR_REPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between auto-repeats (used only with DIR_REPEAT_EN).

Ports:
- clk  input  1  system clock
- resetn  input  1  reset; asynchronous, active-low
- key_n  input  5  raw buttons, active-low, asynchronous to clk; [0]=confirm, [1]=right, [2]=left, [3]=down, [4]=up
- dir  output  3  move code, valid for one cycle; 000 Idle, 001 Up, 010 Down, 011 Right, 100 Left
- confirm  output  1  one-cycle pulse per confirm press

Behaviour:
- Reset (resetn=0, asynchronous):
  - dir=000 and confirm=0 immediately.
  - All synchronizers, debounced levels (released) and counters are cleared.
  - Direction FSM goes to D_IDLE.
- Per key (5 instances):
  - Invert key_n, then pass through a 2-FF synchronizer.
  - Debounce: the counter increments while the synchronized level differs from the debounced level, and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Any reversion before that point restarts the count.
- Latency: raw press to output pulse is 2 + DEBOUNCE_CYCLES + 1 clocks. The outputs are registered.
- Confirm:
  - confirm=1 for exactly one cycle on the rising edge of debounced confirm.
  - No further pulse until the key is released and pressed again.
- Direction FSM, states D_IDLE and D_HELD:
  - D_IDLE, exactly one direction debounced-pressed, no confirm rising edge this cycle: emit its code on dir for one cycle, go to D_HELD.
  - D_IDLE, two or more directions pressed: emit nothing, go to D_HELD. The ambiguous chord is discarded.
  - D_IDLE, confirm rising edge in the same cycle as a direction becoming pressed: confirm wins. dir stays 000, the direction press is consumed and the FSM goes to D_HELD.
  - D_HELD: dir=000. Go to D_IDLE only when all four debounced directions are released.
- Pulses: dir is never non-zero for two consecutive cycles, except when REPEAT_DELAY or REPEAT_PERIOD is 1.
- Keys held at reset deassertion: treated as new presses. They are emitted after the debounce latency.
- Reset asserted mid-debounce or mid-hold: the in-progress count is discarded and no pulse is produced from that partial count.

Optional Feature:
- DIR_REPEAT_EN defined:
  - In D_HELD with exactly one direction pressed, a repeat counter runs.
  - The same code is emitted again REPEAT_DELAY cycles after the initial emit, then every REPEAT_PERIOD cycles while held.
  - The counter clears on release, on a chord change, or on a confirm edge.
- DIR_REPEAT_EN undefined:
  - No repeat counter is synthesized.
  - One command per press; REPEAT_* are ignored.

Decomposition:
- Shared package ttt_pkg, also used by the cursor mover:
  - direction code constants DIR_IDLE, DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT
  - key index constants KEY_CONFIRM .. KEY_UP
- One sub-module, key_debounce (synchronizer + counter + debounced level), instantiated 5 times.
- The direction FSM, confirm edge detect and repeat logic stay in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
1. resetn=0 with random key_n -> dir=000, confirm=0 immediately. After release with key_n=11111, outputs stay 0 for 50 cycles.
2. key_n[4] driven low and held 20 cycles -> dir=001 for exactly one cycle, 7 clocks after the fall. dir=000 on all other cycles. No pulse on release.
3. key_n[3] toggles every 2 cycles for 12 cycles, then stays low -> exactly one dir=010 pulse, 7 clocks after the final fall.
4. key_n[4] and key_n[1] fall in the same cycle -> no dir pulse. After release of both, key_n[2] falls -> dir=100 once.
5. key_n[0] and key_n[3] fall in the same cycle -> confirm=1 for one cycle, dir=000 throughout. A later confirm press after release gives one more confirm pulse.
6. Reset and repeat:
   - resetn pulsed low at cycle 5 of a key_n[1] hold -> outputs clear asynchronously, then dir=011 7 clocks after resetn rises.
   - With DIR_REPEAT_EN defined, a 30-cycle hold of key_n[1] -> dir=011 at clocks 7, 15, 19, 23, 27.
